// File: rtl/noc_pkg.sv
// Shared types and helpers for the PE-array NoC drain path.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package noc_pkg;

    typedef enum logic [1:0] {
        IDLE_S,
        RUN_S,
        FLUSH_S
    } drain_state_t;

    // Valid-convolution output dimension for an image side and kernel side.
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psum_requant.sv
// Rescales a signed psum: arithmetic shift, optional ReLU, saturation to the output width.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module psum_requant #(
    parameter int G_DATA_WIDTH = 16,
    parameter int G_OUT_WIDTH  = 8,
    parameter int G_SHIFT      = 6,
    parameter int G_RELU       = 1
) (
    input  logic [G_DATA_WIDTH-1:0] psum_dat,
    output logic [G_OUT_WIDTH-1:0]  res_dat
);

    localparam int SAT_MAX_I = 2 ** (G_OUT_WIDTH - 1) - 1;
    localparam int SAT_MIN_I = -(2 ** (G_OUT_WIDTH - 1));
    localparam logic signed [G_DATA_WIDTH-1:0] SAT_MAX = G_DATA_WIDTH'(SAT_MAX_I);
    localparam logic signed [G_DATA_WIDTH-1:0] SAT_MIN = G_DATA_WIDTH'(SAT_MIN_I);

    logic signed [G_DATA_WIDTH-1:0] shifted;
    logic signed [G_DATA_WIDTH-1:0] clamped;

    // Shift keeps the sign, ReLU zeroes negatives, then clamp into the output range.
    always_comb begin
        shifted = $signed(psum_dat) >>> G_SHIFT;
        clamped = shifted;
        if ((G_RELU != 0) && shifted[G_DATA_WIDTH-1]) begin
            clamped = '0;
        end
        if (clamped > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (clamped < SAT_MIN) begin
            clamped = SAT_MIN;
        end
        res_dat = clamped[G_OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/psum_drain.sv
// Drains per-column psum FIFOs in raster row order into one requantised ofmap stream.
// Latency: a word popped in cycle t is presented with ofmap_vld_o in cycle t+1.
// Backpressure: pops only when the output register is empty or being accepted; holds while !ofmap_rdy_i.
module psum_drain
    import noc_pkg::*;
#(
    parameter int G_ARRAY_WIDTH  = 4,
    parameter int G_DATA_WIDTH   = 16,
    parameter int G_OUT_WIDTH    = 8,
    parameter int G_SHIFT        = 6,
    parameter int G_RELU         = 1,
    parameter int G_KERNEL_SIZE  = 5,
    parameter int G_IMAGE_HEIGHT = 28,
    parameter int G_IMAGE_WIDTH  = 28
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       start_i,
    input  logic [G_ARRAY_WIDTH-1:0][G_DATA_WIDTH-1:0] psum_i,
    input  logic [G_ARRAY_WIDTH-1:0]                   psum_empty_i,
    output logic [G_ARRAY_WIDTH-1:0]                   psum_rd_en_o,
    output logic [G_OUT_WIDTH-1:0]                     ofmap_o,
    output logic                                       ofmap_vld_o,
    input  logic                                       ofmap_rdy_i,
    output logic                                       ofmap_eol_o,
    output logic                                       ofmap_eof_o,
    output logic                                       busy_o,
    output logic                                       done_o
);

    localparam int OUT_H = out_dim(G_IMAGE_HEIGHT, G_KERNEL_SIZE);
    localparam int OUT_W = out_dim(G_IMAGE_WIDTH, G_KERNEL_SIZE);
    localparam int CW    = cnt_width(OUT_W);
    localparam int RW    = cnt_width(OUT_H);
    localparam int SW    = cnt_width(G_ARRAY_WIDTH);

    localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);
    localparam logic [SW-1:0] SEL_LAST = SW'(G_ARRAY_WIDTH - 1);

    drain_state_t state_q;
    drain_state_t state_d;

    logic [CW-1:0]          col_cnt;
    logic [RW-1:0]          row_cnt;
    logic [SW-1:0]          sel;
    logic                   pop;
    logic                   frame_start;
    logic                   accept;
    logic                   row_end;
    logic                   frame_end;
    logic [G_OUT_WIDTH-1:0] requant_dat;

    assign accept    = ofmap_vld_o && ofmap_rdy_i;
    assign row_end   = (col_cnt == COL_LAST);
    assign frame_end = row_end && (row_cnt == ROW_LAST);
    assign busy_o    = (state_q != IDLE_S);

    psum_requant #(
        .G_DATA_WIDTH (G_DATA_WIDTH),
        .G_OUT_WIDTH  (G_OUT_WIDTH),
        .G_SHIFT      (G_SHIFT),
        .G_RELU       (G_RELU)
    ) u_requant (
        .psum_dat (psum_i[sel]),
        .res_dat  (requant_dat)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE_S;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pop strobe; the pop is gated by reset so nothing leaves a FIFO during reset.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        frame_start  = 1'b0;
        psum_rd_en_o = '0;
        case (state_q)
            IDLE_S: begin
                if (start_i) begin
                    state_d     = RUN_S;
                    frame_start = 1'b1;
                end
            end
            RUN_S: begin
                pop               = rst_ni && !psum_empty_i[sel] && (!ofmap_vld_o || ofmap_rdy_i);
                psum_rd_en_o[sel] = pop;
                if (pop && frame_end) begin
                    state_d = FLUSH_S;
                end
            end
            FLUSH_S: begin
                if (accept) begin
                    state_d = IDLE_S;
                end
            end
            default: begin
                state_d = IDLE_S;
            end
        endcase
    end

    // Raster position counters; sel follows row_cnt modulo the array width without a divider.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || frame_start) begin
            col_cnt <= '0;
            row_cnt <= '0;
            sel     <= '0;
        end else if (pop) begin
            if (row_end) begin
                col_cnt <= '0;
                row_cnt <= frame_end ? '0 : row_cnt + 1'b1;
                sel     <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Output register: a pop loads a new word (also when the old one leaves this cycle);
    // an accept without a pop empties it. Markers are dropped with the valid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ofmap_o     <= '0;
            ofmap_vld_o <= 1'b0;
            ofmap_eol_o <= 1'b0;
            ofmap_eof_o <= 1'b0;
        end else if (pop) begin
            ofmap_o     <= requant_dat;
            ofmap_vld_o <= 1'b1;
            ofmap_eol_o <= row_end;
            ofmap_eof_o <= frame_end;
        end else if (accept) begin
            ofmap_vld_o <= 1'b0;
            ofmap_eol_o <= 1'b0;
            ofmap_eof_o <= 1'b0;
        end
    end

    // Done pulses the cycle after the eof word is handed off.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            done_o <= 1'b0;
        end else begin
            done_o <= (state_q == FLUSH_S) && accept;
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: FIFO model feeding the DUT, expected words queued at fill time.
// Latency: n/a.
// Backpressure: ready driven from the stimulus, optionally random at 30 percent duty.
module tb_psum_drain;

    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int OUT = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   rdy   = 1'b1;
    logic [AW-1:0][DW-1:0]  psum;
    logic [AW-1:0]          empty;
    logic [AW-1:0]          rd_en;
    logic [7:0]             ofmap;
    logic                   vld, eol, eof, busy, done;

    psum_drain u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .psum_i       (psum),
        .psum_empty_i (empty),
        .psum_rd_en_o (rd_en),
        .ofmap_o      (ofmap),
        .ofmap_vld_o  (vld),
        .ofmap_rdy_i  (rdy),
        .ofmap_eol_o  (eol),
        .ofmap_eof_o  (eof),
        .busy_o       (busy),
        .done_o       (done)
    );

    // Second instance: ReLU off, 1x3 output frame, fed directly from the stimulus.
    logic                   start2 = 1'b0;
    logic [DW-1:0]          p2 = '0;
    logic [AW-1:0][DW-1:0]  psum2;
    logic [AW-1:0]          e2 = '1;
    logic [AW-1:0]          rd2;
    logic [7:0]             ofmap2;
    logic                   vld2, eol2, eof2, busy2, done2;
    logic                   rdy2 = 1'b1;

    assign psum2 = {AW{p2}};

    psum_drain #(
        .G_RELU         (0),
        .G_KERNEL_SIZE  (5),
        .G_IMAGE_HEIGHT (5),
        .G_IMAGE_WIDTH  (7)
    ) u_dut2 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start2),
        .psum_i       (psum2),
        .psum_empty_i (e2),
        .psum_rd_en_o (rd2),
        .ofmap_o      (ofmap2),
        .ofmap_vld_o  (vld2),
        .ofmap_rdy_i  (rdy2),
        .ofmap_eol_o  (eol2),
        .ofmap_eof_o  (eof2),
        .busy_o       (busy2),
        .done_o       (done2)
    );

    // FWFT FIFO model per column.
    logic [DW-1:0] mem [AW][256];
    logic [7:0]    wr_ptr [AW];
    logic [7:0]    rd_ptr [AW];
    logic          fifo_clr = 1'b1;
    logic [AW-1:0] blk = '0;

    for (genvar c = 0; c < AW; c++) begin : g_fifo
        assign psum[c]  = mem[c][rd_ptr[c]];
        assign empty[c] = (rd_ptr[c] == wr_ptr[c]) || blk[c];
    end

    always @(posedge clk) begin
        for (int c = 0; c < AW; c++) begin
            if (fifo_clr)      rd_ptr[c] <= '0;
            else if (rd_en[c]) rd_ptr[c] <= rd_ptr[c] + 8'd1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference requantiser: floor division by 64, ReLU, clamp to int8.
    function automatic logic [7:0] ref_q(input logic [15:0] p, input bit relu);
        int v;
        int s;
        v = $signed(p);
        s = v / 64;
        if ((v % 64 != 0) && (v < 0)) s = s - 1;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    // Scoreboard entry: {data, eol, eof}.
    logic [9:0] exp_q [$];

    int   acc_total  = 0;
    int   pop_total  = 0;
    int   done_total = 0;
    int   eol_total  = 0;
    int   eof_total  = 0;
    int   acc_base   = 0;
    int   pop_base   = 0;
    int   done_base  = 0;
    int   eol_base   = 0;
    int   eof_base   = 0;
    bit   mon_en     = 1'b0;
    logic prev_pop    = 1'b0;
    logic prev_stall  = 1'b0;
    logic prev_eofacc = 1'b0;
    logic [9:0] prev_word = '0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (|rd_en) begin
                chk("rd_sel", rd_en, 32'(1 << (((pop_total - pop_base) / OUT) % AW)));
                chk("pop_gap", !vld || rdy, 1);
            end
            if (prev_pop)   chk("lat_vld", vld, 1);
            if (prev_stall) chk("hold", {ofmap, eol, eof}, prev_word);
            chk("done", done, prev_eofacc);
            if (vld && rdy) begin
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("word", {ofmap, eol, eof}, exp_q.pop_front());
            end
        end
        pop_total   <= pop_total + ((|rd_en) ? 1 : 0);
        acc_total   <= acc_total + ((vld && rdy) ? 1 : 0);
        eol_total   <= eol_total + ((vld && rdy && eol) ? 1 : 0);
        eof_total   <= eof_total + ((vld && rdy && eof) ? 1 : 0);
        done_total  <= done_total + (done ? 1 : 0);
        prev_pop    <= mon_en && (|rd_en);
        prev_stall  <= mon_en && vld && !rdy;
        prev_eofacc <= mon_en && vld && rdy && eof;
        prev_word   <= {ofmap, eol, eof};
    end

    task automatic push_word(input int col, input logic [15:0] v, input logic [9:0] e);
        mem[col][wr_ptr[col]] = v;
        wr_ptr[col] = wr_ptr[col] + 8'd1;
        exp_q.push_back(e);
    endtask

    // mode 0: constant 0x0100; mode 1: requant corners first, then random psums.
    task automatic fill_frame(input int mode);
        logic [15:0] v;
        int k;
        k = 0;
        for (int r = 0; r < OUT; r++) begin
            for (int c = 0; c < OUT; c++) begin
                if (mode == 0)   v = 16'h0100;
                else if (k == 0) v = 16'h7FFF;
                else if (k == 1) v = 16'h8000;
                else if (k == 2) v = 16'hFFC0;
                else             v = 16'($urandom);
                push_word(r % AW, v, {ref_q(v, 1'b1), c == OUT - 1, (r == OUT - 1) && (c == OUT - 1)});
                k++;
            end
        end
    endtask

    task automatic fifo_reset();
        fifo_clr = 1'b1;
        for (int c = 0; c < AW; c++) wr_ptr[c] = '0;
        @(posedge clk);
        #1 fifo_clr = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1;
        pop_base  = pop_total;
        acc_base  = acc_total;
        done_base = done_total;
        eol_base  = eol_total;
        eof_base  = eof_total;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int budget, input bit rnd);
        int n;
        n = 0;
        while (done_total == done_base && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd) rdy = ($urandom_range(0, 99) < 30);
            n++;
        end
        rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_in_budget"}, n < budget, 1);
        chk({tag, "_words"}, acc_total - acc_base, OUT * OUT);
        chk({tag, "_eol_cnt"}, eol_total - eol_base, OUT);
        chk({tag, "_eof_cnt"}, eof_total - eof_base, 1);
        chk({tag, "_done_cnt"}, done_total - done_base, 1);
        chk({tag, "_sb_left"}, exp_q.size(), 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_words(input string tag, input int target);
        int n;
        n = 0;
        while (acc_total - acc_base < target && n < 4000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_reached"}, n < 4000, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ofmap"}, ofmap, 0);
        chk({tag, "_vld"}, vld, 0);
        chk({tag, "_eol"}, eol, 0);
        chk({tag, "_eof"}, eof, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
    endtask

    initial begin
        for (int c = 0; c < AW; c++) wr_ptr[c] = '0;
        repeat (3) @(posedge clk);
        #1 fifo_clr = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        // start coinciding with reset must be ignored
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("start_in_rst", busy, 0);
        repeat (2) @(negedge clk);
        chk("still_idle", busy, 0);
        mon_en = 1'b1;

        // ReLU-off corners on the small instance
        @(posedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        p2 = 16'h8000;
        e2 = 4'b1110;
        @(negedge clk);
        chk("d2_pop0", rd2, 1);
        @(posedge clk);
        #1 p2 = 16'hFFC0;
        @(negedge clk);
        chk("d2_min", ofmap2, 8'h80);
        chk("d2_vld0", vld2, 1);
        chk("d2_eol0", eol2, 0);
        chk("d2_pop1", rd2, 1);
        @(posedge clk);
        #1 p2 = 16'h7FFF;
        @(negedge clk);
        chk("d2_neg1", ofmap2, 8'hFF);
        chk("d2_pop2", rd2, 1);
        @(posedge clk);
        #1 e2 = 4'b1111;
        @(negedge clk);
        chk("d2_max", ofmap2, 8'h7F);
        chk("d2_eol", eol2, 1);
        chk("d2_eof", eof2, 1);
        chk("d2_no_pop", rd2, 0);
        chk("d2_busy", busy2, 1);
        @(negedge clk);
        chk("d2_done", done2, 1);
        chk("d2_idle", busy2, 0);

        // Frame 1: constant psums, ready high, spurious start mid-frame
        fill_frame(0);
        start_frame();
        wait_words("f1_mid", 200);
        #1;
        chk("f1_busy", busy, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_frame("f1", 3000, 1'b0);

        // Frame 2: corners plus random psums, random ready at 30 percent
        fifo_reset();
        fill_frame(1);
        start_frame();
        wait_frame("f2", 8000, 1'b1);

        // Frame 3: column 2 starved
        fifo_reset();
        fill_frame(0);
        blk = 4'b0100;
        start_frame();
        repeat (120) @(posedge clk);
        #1;
        chk("stall_words", acc_total - acc_base, 2 * OUT);
        chk("stall_pops", pop_total - pop_base, 2 * OUT);
        chk("stall_busy", busy, 1);
        @(negedge clk);
        chk("stall_rd_en", rd_en, 0);
        @(posedge clk);
        #1 blk = '0;
        wait_frame("f3", 3000, 1'b0);

        // Frame 4: reset around word 100, then a clean frame
        fifo_reset();
        fill_frame(0);
        start_frame();
        wait_words("f4_w100", 100);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("rst_no_pop", rd_en, 0);
        @(negedge clk);
        check_reset_vals("midrst");
        exp_q.delete();
        fifo_reset();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        fill_frame(0);
        start_frame();
        wait_frame("f5", 3000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
